fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter N, default 32: instruction and address width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000: PC loaded on reset.
REQ-003 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port imem_req, output, 1: fetch request, accepted in the cycle it is high.
REQ-006 SHALL have port imem_addr, output, N: fetch address, always equal to the current PC register.
REQ-007 SHALL have port imem_rvalid, input, 1: response strobe for the single outstanding request.
REQ-008 SHALL have port imem_rdata, input, N: response instruction word.
REQ-009 SHALL have port redirect_valid, input, 1: branch or jump taken; refetch from redirect_pc.
REQ-010 SHALL have port redirect_pc, input, N: redirect target; bits [1:0] are ignored and treated as 0.
REQ-011 SHALL have port instr_valid, output, 1: instruction word available to the decoder.
REQ-012 SHALL have port instr_ready, input, 1: decoder accepts the word; a pop occurs when instr_valid and instr_ready are both high.
REQ-013 SHALL have port instruction, output, N: head word, 0 when the buffer is empty.
REQ-014 SHALL have port instr_pc, output, N: PC of the head word, 0 when the buffer is empty.

Function
REQ-015 SHALL hold a 2-entry FIFO of {pc, word} pairs with occupancy count 0..2.
REQ-016 SHALL implement the FSM states ISSUE (nothing outstanding), WAIT (one request outstanding) and DROP (discard the next response).
REQ-017 SHALL never have more than one outstanding request.
REQ-018 In ISSUE with count<2 and no redirect, SHALL assert imem_req, latch req_pc<=PC, set PC<=PC+4 (mod 2^N), and go to WAIT.
REQ-019 In ISSUE with count==2, SHALL keep imem_req low and stay in ISSUE.
REQ-020 In WAIT on imem_rvalid, SHALL push {req_pc, imem_rdata}.
REQ-021 In the same WAIT cycle, if count+1-pop<2, SHALL issue the next request back-to-back and stay in WAIT; otherwise SHALL go to ISSUE.
REQ-022 With zero-latency memory response, sustained throughput SHALL be one instruction per cycle.
REQ-023 In WAIT without imem_rvalid, SHALL hold all state.
REQ-024 Push and pop in the same cycle SHALL leave count unchanged.
REQ-025 A push into a full FIFO SHALL NOT be reachable; an assertion SHALL flag it.
REQ-026 A redirect in any state SHALL, on that edge, flush the FIFO (count<=0) and load PC<={redirect_pc[N-1:2],2'b00}.
REQ-027 In the redirect cycle, instr_valid SHALL be forced to 0 and imem_req SHALL be held low.
REQ-028 On redirect in WAIT without imem_rvalid, SHALL go to DROP; with imem_rvalid in the same cycle, SHALL discard the response and go to ISSUE.
REQ-029 In DROP, SHALL discard imem_rvalid data, keep imem_req low, and go to ISSUE on imem_rvalid.
REQ-030 On a redirect in DROP, SHALL update PC and remain in DROP unless imem_rvalid is also high, in which case it SHALL go to ISSUE.
REQ-031 On redirect in ISSUE, SHALL stay in ISSUE.
REQ-032 instr_valid SHALL equal (count!=0) and not redirect_valid.
REQ-033 instruction and instr_pc SHALL be driven directly from FIFO head registers, with no combinational path from imem_rdata.

Reset
REQ-034 While rst is high: PC=RESET_PC, state=ISSUE, count=0, FIFO contents=0, imem_req=0, instr_valid=0, instruction=0, instr_pc=0.
REQ-035 An assertion of rst mid-WAIT SHALL abandon the outstanding request, and any imem_rvalid during or after reset before a new request SHALL be ignored.
REQ-036 The first imem_req SHALL occur in the first clock cycle after rst deasserts.

Verification
REQ-037 Reset release, 1-cycle memory, instr_ready=1 -> imem_addr sequence 0x0,0x4,0x8; instr_pc follows one cycle behind each response.
REQ-038 instr_ready=0 for 6 cycles -> count saturates at 2, imem_req stays low, head remains 0x0/word0; on ready, words pop in order.
REQ-039 Redirect to 0x103 while WAIT and response 2 cycles later -> DROP entered, stale word never appears, next imem_addr=0x100.
REQ-040 Redirect coincident with imem_rvalid and a full FIFO -> instr_valid=0 that cycle, count=0 next cycle, next fetch from target.
REQ-041 Async rst pulse mid-WAIT between clock edges -> outputs clear immediately, late rvalid ignored, fetch restarts at RESET_PC.
REQ-042 PC=0xFFFF_FFFC fetch -> next imem_addr wraps to 0x0000_0000.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end. Keeps at most one memory request
// in flight, buffers returned words with their PCs in a two-entry FIFO, and
// handles branch/jump redirects by flushing the buffer and, if a request is
// still in flight, discarding its response when it arrives.
module fetch_unit #(
   parameter int           N        = 32,
   parameter logic [N-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic         clk,
   input  logic         rst,
   output logic         imem_req,
   output logic [N-1:0] imem_addr,
   input  logic         imem_rvalid,
   input  logic [N-1:0] imem_rdata,
   input  logic         redirect_valid,
   input  logic [N-1:0] redirect_pc,
   output logic         instr_valid,
   input  logic         instr_ready,
   output logic [N-1:0] instruction,
   output logic [N-1:0] instr_pc
);

   localparam int DEPTH = 2;

   // ISSUE: nothing in flight; WAIT: one request in flight;
   // DROP: one request in flight whose response must be thrown away
   typedef enum logic [1:0] {
      ISSUE = 2'd0,
      WAIT  = 2'd1,
      DROP  = 2'd2
   } state_t;

   state_t       state_reg, state_next;
   logic [N-1:0] pc_reg, pc_next;
   logic [N-1:0] req_pc_reg, req_pc_next;
   logic [1:0]   count_reg, count_next;
   logic [N-1:0] fifo_pc_reg   [DEPTH];
   logic [N-1:0] fifo_word_reg [DEPTH];

   logic         issue;
   logic         push;
   logic         pop;
   logic [1:0]   count_after_pop;
   logic [N-1:0] redirect_target;

   // Redirect targets are word aligned; the low two bits are simply masked.
   assign redirect_target = redirect_pc & ~N'(3);

   // The decoder never sees a word in the cycle the pipeline is redirecting.
   assign instr_valid     = (count_reg != 2'd0) && !redirect_valid;
   assign pop             = instr_valid && instr_ready;
   assign count_after_pop = count_reg - {1'b0, pop};

   // Outputs come straight from registers so imem_rdata never reaches the decoder
   // combinationally; an empty buffer shows zeros.
   assign instruction = (count_reg != 2'd0) ? fifo_word_reg[0] : '0;
   assign instr_pc    = (count_reg != 2'd0) ? fifo_pc_reg[0]   : '0;

   assign imem_addr = pc_reg;
   // The request is masked while reset is held, when the state machine
   // would otherwise already look ready to issue.
   assign imem_req  = issue && !rst;

   // State, PC and occupancy registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= ISSUE;
         pc_reg     <= RESET_PC;
         req_pc_reg <= '0;
         count_reg  <= 2'd0;
      end else begin
         state_reg  <= state_next;
         pc_reg     <= pc_next;
         req_pc_reg <= req_pc_next;
         count_reg  <= count_next;
      end
   end

   // Next-state, request issue and buffer push decisions
   always_comb begin
      state_next  = state_reg;
      pc_next     = pc_reg;
      req_pc_next = req_pc_reg;
      count_next  = count_reg;
      issue       = 1'b0;
      push        = 1'b0;

      case (state_reg)
         ISSUE: begin
            if (!redirect_valid && count_reg < 2'd2) begin
               issue      = 1'b1;
               state_next = WAIT;
            end
         end
         WAIT: begin
            if (redirect_valid) begin
               // A response arriving with the redirect is stale and is dropped
               // here; otherwise the one still to come is dropped in DROP.
               state_next = imem_rvalid ? ISSUE : DROP;
            end else if (imem_rvalid) begin
               push = 1'b1;
               // Chain the next request only if the buffer will still have
               // room for its response: count + 1 - pop < 2.
               if (count_after_pop == 2'd0) begin
                  issue = 1'b1;
               end else begin
                  state_next = ISSUE;
               end
            end
         end
         DROP: begin
            if (imem_rvalid) begin
               state_next = ISSUE;
            end
         end
         default: begin
            state_next = ISSUE;
         end
      endcase

      if (issue) begin
         req_pc_next = pc_reg;
         pc_next     = pc_reg + N'(4);
      end

      if (redirect_valid) begin
         pc_next    = redirect_target;
         count_next = 2'd0;
      end else begin
         count_next = count_reg - {1'b0, pop} + {1'b0, push};
      end
   end

   // FIFO storage: entry 0 is the head; a pop shifts entry 1 down and a push
   // lands in the first free slot after that shift.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            fifo_pc_reg[i]   <= '0;
            fifo_word_reg[i] <= '0;
         end
      end else begin
         if (pop) begin
            fifo_pc_reg[0]   <= fifo_pc_reg[1];
            fifo_word_reg[0] <= fifo_word_reg[1];
         end
         if (push) begin
            fifo_pc_reg[count_after_pop[0]]   <= req_pc_reg;
            fifo_word_reg[count_after_pop[0]] <= imem_rdata;
         end
      end
   end

   // A request is only chained while a slot stays free, so a push can never
   // meet a full buffer.
   a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
      !(push && count_reg == 2'd2));

endmodule
